ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter, the send side of the PS/2 keyboard link that `user_input` already receives on. It accepts a command byte from the SoC (for example 0xED "set LEDs" or 0xFF "reset") and runs the PS/2 request-to-send sequence on the shared clock and data lines. It drives both lines open-drain through output-enable signals and reports completion, missing device acknowledge, and (optionally) timeout.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_sync_edge.sv | 45 ++++
 rtl/ps2_host_tx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 types and constants for the host transmitter and
//               the keyboard receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int PS2_IDX_W = 4;

  // Defaults for a 50 MHz system clock: 100 us inhibit, 15 ms watchdog.
  localparam int PS2_INHIBIT_CYCLES_50M = 5000;
  localparam int PS2_TIMEOUT_CYCLES_50M = 750000;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_sync_edge.sv
// ============================================================================
// Module      : ps2_sync_edge
// Description : Two-flop synchronizer for one PS/2 pad plus falling-edge
//               detector on the synchronized value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fe
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Reset to the idle-high line level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q;
  assign fe       = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (request-to-send,
//               11-clock frame, device acknowledge). Optional watchdog is
//               compiled in with macro PS2_HOST_TX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_50M,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_50M
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic       busy,
  output logic       done,
  output logic       err_nack,
  output logic       err_timeout,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES);

  logic clk_sync, clk_fe, dat_sync, dat_fe;

  ps2_sync_edge u_clk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ps2_clk_in),
    .sync_out (clk_sync),
    .fe       (clk_fe)
  );

  ps2_sync_edge u_dat_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ps2_dat_in),
    .sync_out (dat_sync),
    .fe       (dat_fe)
  );

  logic unused_dat_fe;
  assign unused_dat_fe = dat_fe;

  ps2_state_e           state_q, state_d;
  logic [INH_W-1:0]     cnt_q, cnt_d;
  logic [PS2_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]           data_q, data_d;
  logic                 dat_oe_q, dat_oe_d;
  logic                 done_q, done_d;
  logic                 nack_q, nack_d;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] wd_q, wd_d;
  logic             tmo_q, tmo_d;
  logic             wd_active;
`else
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    nack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dat_oe_d = 1'b0;
        if (write) begin
          data_d  = data_in;
          cnt_d   = INH_LOAD;
          state_d = ST_INHIBIT;
        end
      end
      // Leaving on count 1 gives INHIBIT_CYCLES here plus the START cycle.
      ST_INHIBIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= INH_W'(1)) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        idx_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_fe) begin
          idx_d = idx_q + 1'b1;
          if (idx_q < PS2_IDX_W'(8)) begin
            dat_oe_d = ~data_q[idx_q[2:0]];
          end else if (idx_q == PS2_IDX_W'(8)) begin
            dat_oe_d = ~odd_parity(data_q);
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fe) begin
          done_d  = ~dat_sync;
          nack_d  = dat_sync;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
    wd_active = (state_q == ST_START) || (state_q == ST_SHIFT) ||
                (state_q == ST_ACK);
    tmo_d     = 1'b0;
    wd_d      = wd_q;
    if (state_q == ST_INHIBIT) begin
      wd_d = '0;
    end else if (wd_active) begin
      wd_d = wd_q + 1'b1;
    end
    // An acknowledge landing on the expiry cycle takes precedence.
    if (wd_active && (wd_q == TMO_LAST) && !((state_q == ST_ACK) && clk_fe)) begin
      tmo_d    = 1'b1;
      dat_oe_d = 1'b0;
      wd_d     = '0;
      state_d  = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end
  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign busy       = (state_q != ST_IDLE);
  assign ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_START);
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign err_nack   = nack_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int TMO = 8000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       write = 1'b0;
  logic       busy, done, err_nack, err_timeout, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;

  // Open-drain bus: the line is high unless host or device pulls it low.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .write       (write),
    .busy        (busy),
    .done        (done),
    .err_nack    (err_nack),
    .err_timeout (err_timeout),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_dat_in  (ps2_dat_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_dat_oe  (ps2_dat_oe)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   run = 0, last_run = 0, done_cnt = 0, nack_cnt = 0, tmo_cnt = 0;
  int   evt_cyc = 0, tmo_cyc = 0, start_cyc = 0;
  logic dat_prev = 1'b0;

  always @(negedge clk) begin
    run <= ps2_clk_oe ? run + 1 : 0;
    if (!ps2_clk_oe && run != 0) last_run <= run;
    if (done) begin done_cnt <= done_cnt + 1; evt_cyc <= cyc; end
    if (err_nack) begin nack_cnt <= nack_cnt + 1; evt_cyc <= cyc; end
    if (err_timeout) begin tmo_cnt <= tmo_cnt + 1; tmo_cyc <= cyc; end
    if (ps2_dat_oe && !dat_prev && ps2_clk_oe) start_cyc <= cyc;
    dat_prev <= ps2_dat_oe;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Frame as seen on the data line: start 0, LSB-first data, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  task automatic device_frame(input int half, input bit ack, input int stop_after,
                              output logic [10:0] bits, output int fe11, output bit ok);
    int guard = 0;
    bits = '0; fe11 = 0; ok = 1'b0;
    while (!(ps2_dat_in === 1'b0 && ps2_clk_in === 1'b1) && guard < INH + 200) begin
      wait_cyc(1);
      guard++;
    end
    if (guard >= INH + 200) return;
    bits[0] = ps2_dat_in;
    wait_cyc(half);
    for (int i = 1; i <= 10; i++) begin
      if (i > stop_after) begin ok = 1'b1; return; end
      dev_clk_low = 1'b1; wait_cyc(half);
      dev_clk_low = 1'b0; bits[i] = ps2_dat_in; wait_cyc(half);
    end
    dev_dat_low = ack; wait_cyc(4);
    dev_clk_low = 1'b1; fe11 = cyc; wait_cyc(half);
    dev_clk_low = 1'b0; wait_cyc(half);
    dev_dat_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] d);
    data_in = d; write = 1'b1;
    wait_cyc(1);
    write = 1'b0; data_in = 8'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (busy !== 1'b0 && g < 500) begin wait_cyc(1); g++; end
    check(tag, busy, 0);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input int half, input bit overlap);
    logic [10:0] bits;
    int fe11, d0, n0;
    bit ok;
    d0 = done_cnt; n0 = nack_cnt;
    fork
      device_frame(half, ack, 10, bits, fe11, ok);
      begin
        do_write(d);
        check("write_busy", busy, 1);
        check("write_clk_oe", ps2_clk_oe, 1);
        if (overlap) begin
          wait_cyc(INH + 6 * half);
          check("overlap_busy", busy, 1);
          do_write(8'h55);
        end
      end
    join
    wait_idle("idle_after_frame");
    check("device_ok", ok, 1);
    check("frame_bits", bits, model_frame(d));
    check("inhibit_len", last_run, INH + 1);
    check("done_count", done_cnt - d0, ack ? 1 : 0);
    check("nack_count", nack_cnt - n0, ack ? 0 : 1);
    check("pulse_latency", evt_cyc - fe11, 3);
  endtask

  initial begin
    logic [10:0] bits, exp_frame;
    int fe11, d0, n0, t0, g;
    bit ok;

    wait_cyc(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", err_nack, 0);
    check("rst_timeout", err_timeout, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    rst = 1'b0;
    wait_cyc(2);

    run_frame(8'hED, 1'b1, 25, 1'b0);
    run_frame(8'h01, 1'b1, 20, 1'b0);
    run_frame(8'h00, 1'b1, 20, 1'b0);
    run_frame(8'($urandom_range(0, 255)), 1'b0, $urandom_range(12, 30), 1'b0);
    run_frame(8'hED, 1'b1, 25, 1'b1);
    for (int k = 0; k < 2; k++) begin
      run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                $urandom_range(12, 30), 1'b0);
    end

    // Reset in the middle of the data bits.
    d0 = done_cnt; n0 = nack_cnt;
    fork
      device_frame(20, 1'b1, 4, bits, fe11, ok);
      do_write(8'hA7);
    join
    exp_frame = model_frame(8'hA7);
    check("partial_bits", bits[4:0], exp_frame[4:0]);
    rst = 1'b1;
    wait_cyc(1);
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_dat_oe", ps2_dat_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_nack", err_nack, 0);
    rst = 1'b0;
    wait_cyc(100);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_nack", nack_cnt - n0, 0);

    // Silent device.
    t0 = tmo_cnt;
    do_write(8'hFF);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    g = 0;
    while (tmo_cnt == t0 && g < INH + TMO + 100) begin wait_cyc(1); g++; end
    check("tmo_count", tmo_cnt - t0, 1);
    check("tmo_latency", tmo_cyc - start_cyc, TMO);
    check("tmo_clk_oe", ps2_clk_oe, 0);
    check("tmo_dat_oe", ps2_dat_oe, 0);
    check("tmo_busy", busy, 0);
`else
    g = 0;
    wait_cyc(INH + TMO + 200);
    check("notmo_busy", busy, 1);
    check("notmo_count", tmo_cnt - t0, g);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("notmo_rst_busy", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
